// File: rtl/fetch_pc_unit.sv
// Fetch PC register with fixed-priority next-PC select and an optional return-address stack.
// npc is combinational, pc follows one edge later; stall freezes state. RAS enabled by FETCH_RAS_EN.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_ctr,
  input  logic [15:0] imm16,
  input  logic        j_ctr,
  input  logic        jal_ctr,
  input  logic [25:0] imm26,
  input  logic        jr_ctr,
  input  logic        ret_ctr,
  input  logic [31:0] rsd,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [31:0] jal_pc,
  output logic [31:0] ras_top,
  output logic        ras_valid,
  output logic        ras_full,
  output logic        ras_mispredict
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] seq_pc, br_pc, jt_pc, npc_w;

  always_comb begin
    seq_pc = pc_q + 32'd4;
    br_pc  = seq_pc + {{14{imm16[15]}}, imm16, 2'b00};
    jt_pc  = {seq_pc[31:28], imm26, 2'b00};
    npc_w  = seq_pc;
    if (jr_ctr)                npc_w = rsd;
    else if (j_ctr || jal_ctr) npc_w = jt_pc;
    else if (branch_ctr)       npc_w = br_pc;
    pc_d = stall ? pc_q : npc_w;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_VEC;
    else       pc_q <= pc_d;
  end

  assign pc     = pc_q;
  assign npc    = npc_w;
  assign jal_pc = seq_pc;

`ifdef FETCH_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [31:0]      ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             misp_q, misp_d;
  logic             push, pop;
  logic [31:0]      top;

  // ptr_q names the most recent entry; a push past full lands on the oldest slot.
  always_comb begin
    push   = jal_ctr && !jr_ctr && !stall;
    pop    = jr_ctr && ret_ctr && !stall && (cnt_q != '0);
    top    = (cnt_q != '0) ? ras_mem_q[ptr_q] : 32'd0;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    misp_d = 1'b0;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != DEPTH_C) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop) begin
      ptr_d  = ptr_q - PTR_W'(1);
      cnt_d  = cnt_q - CNT_W'(1);
      misp_d = (top != rsd);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      misp_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      misp_q <= misp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) ras_mem_q[ptr_d] <= seq_pc;
  end

  assign ras_top        = top;
  assign ras_valid      = (cnt_q != '0);
  assign ras_full       = (cnt_q == DEPTH_C);
  assign ras_mispredict = misp_q;
`else
  logic unused_cfg;
  assign unused_cfg     = ^{ret_ctr, RAS_DEPTH[0]};
  assign ras_top        = 32'd0;
  assign ras_valid      = 1'b0;
  assign ras_full       = 1'b0;
  assign ras_mispredict = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_pc_unit;
  localparam logic [31:0] RV    = 32'h0000_3000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, stall, branch_ctr, j_ctr, jal_ctr, jr_ctr, ret_ctr;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rsd;
  logic [31:0] pc, npc, jal_pc, ras_top;
  logic        ras_valid, ras_full, ras_mispredict;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_misp;
  logic        m_stalled;

  fetch_pc_unit #(.RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_ctr(branch_ctr), .imm16(imm16),
    .j_ctr(j_ctr), .jal_ctr(jal_ctr), .imm26(imm26), .jr_ctr(jr_ctr), .ret_ctr(ret_ctr),
    .rsd(rsd), .pc(pc), .npc(npc), .jal_pc(jal_pc), .ras_top(ras_top),
    .ras_valid(ras_valid), .ras_full(ras_full), .ras_mispredict(ras_mispredict)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_npc();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (jr_ctr) return rsd;
    if (j_ctr || jal_ctr) return {seq[31:28], imm26, 2'b00};
    if (branch_ctr) return seq + 32'(int'($signed(imm16)) * 4);
    return seq;
  endfunction

  function automatic logic [31:0] m_top();
    return (m_ras.size() > 0) ? m_ras[$] : 32'd0;
  endfunction

  task automatic model_edge();
    logic [31:0] nx;
    nx = ref_npc();
    m_stalled = stall && !reset;
    m_misp = 1'b0;
    if (reset) begin
      m_pc = RV;
      m_ras.delete();
    end else if (!stall) begin
`ifdef FETCH_RAS_EN
      if (jr_ctr && ret_ctr) begin
        if (m_ras.size() > 0) begin
          m_misp = (m_ras[$] != rsd);
          void'(m_ras.pop_back());
        end
      end else if (!jr_ctr && jal_ctr) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
`endif
      m_pc = nx;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; stall = 0; branch_ctr = 0; j_ctr = 0; jal_ctr = 0; jr_ctr = 0; ret_ctr = 0;
    imm16 = '0; imm26 = '0; rsd = '0;
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (pc !== RV) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RV); end
    n_tests++; if (jal_pc !== 32'h3004) begin n_fail++; $display("FAIL reset_jal_pc: got %h want %h", jal_pc, 32'h3004); end
    n_tests++; if (ras_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ras_valid: got %b want 0", ras_valid); end
    n_tests++; if (ras_mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_misp: got %b want 0", ras_mispredict); end
  endtask

  task automatic test_idle_seq();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h3004, 32'h3008, 32'h300C};
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (pc !== exp_pc[i]) begin n_fail++; $display("FAIL idle_seq%0d: got %h want %h", i, pc, exp_pc[i]); end
    end
  endtask

  task automatic test_branch();
    tick();
    n_tests++; if (pc !== 32'h3010) begin n_fail++; $display("FAIL br_start_pc: got %h want %h", pc, 32'h3010); end
    branch_ctr = 1; imm16 = 16'hFFFC; #1;
    n_tests++; if (npc !== 32'h3004) begin n_fail++; $display("FAIL br_back: got %h want %h", npc, 32'h3004); end
    n_tests++; if (jal_pc !== 32'h3014) begin n_fail++; $display("FAIL br_jal_pc: got %h want %h", jal_pc, 32'h3014); end
    imm16 = 16'h0003; #1;
    n_tests++; if (npc !== 32'h3020) begin n_fail++; $display("FAIL br_fwd: got %h want %h", npc, 32'h3020); end
    tick();
    n_tests++; if (pc !== 32'h3020) begin n_fail++; $display("FAIL br_taken_pc: got %h want %h", pc, 32'h3020); end
    idle();
  endtask

  task automatic test_priority();
    do_reset();
    branch_ctr = 1; jr_ctr = 1; j_ctr = 1; rsd = 32'h4000;
    imm16 = 16'($urandom); imm26 = 26'($urandom); #1;
    n_tests++; if (npc !== 32'h4000) begin n_fail++; $display("FAIL prio_npc: got %h want %h", npc, 32'h4000); end
    stall = 1; tick();
    n_tests++; if (pc !== 32'h3000) begin n_fail++; $display("FAIL prio_stall_pc: got %h want %h", pc, 32'h3000); end
    stall = 0; tick();
    n_tests++; if (pc !== 32'h4000) begin n_fail++; $display("FAIL prio_pc: got %h want %h", pc, 32'h4000); end
    n_tests++; if (ras_valid !== 1'b0) begin n_fail++; $display("FAIL prio_no_push: got %b want 0", ras_valid); end
    idle();
  endtask

`ifdef FETCH_RAS_EN
  task automatic test_ras_basic();
    do_reset();
    jal_ctr = 1; imm26 = 26'h000C40; #1;
    n_tests++; if (npc !== 32'h3100) begin n_fail++; $display("FAIL jal_npc: got %h want %h", npc, 32'h3100); end
    tick(); idle();
    n_tests++; if (ras_top !== 32'h3004) begin n_fail++; $display("FAIL jal_top: got %h want %h", ras_top, 32'h3004); end
    n_tests++; if (ras_valid !== 1'b1) begin n_fail++; $display("FAIL jal_valid: got %b want 1", ras_valid); end
    jr_ctr = 1; ret_ctr = 1; rsd = 32'h3004; #1;
    n_tests++; if (npc !== 32'h3004) begin n_fail++; $display("FAIL ret_npc: got %h want %h", npc, 32'h3004); end
    tick(); idle();
    n_tests++; if (ras_mispredict !== 1'b0) begin n_fail++; $display("FAIL ret_misp: got %b want 0", ras_mispredict); end
    n_tests++; if (ras_valid !== 1'b0) begin n_fail++; $display("FAIL ret_valid: got %b want 0", ras_valid); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] links [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      jal_ctr = 1; imm26 = 26'h1000 + 26'(i * 16);
      links[i] = pc + 32'd4;
      tick();
    end
    idle();
    n_tests++; if (ras_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", ras_full); end
    n_tests++; if (ras_top !== links[4]) begin n_fail++; $display("FAIL ovf_top: got %h want %h", ras_top, links[4]); end
    for (int i = 4; i >= 1; i--) begin
      jr_ctr = 1; ret_ctr = 1; rsd = links[i]; tick();
      n_tests++; if (ras_mispredict !== 1'b0) begin n_fail++; $display("FAIL ovf_pop%0d_misp: got %b want 0", i, ras_mispredict); end
    end
    idle();
    n_tests++; if (ras_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", ras_valid); end
    jr_ctr = 1; ret_ctr = 1; rsd = 32'($urandom); tick(); idle();
    n_tests++; if (ras_mispredict !== 1'b0) begin n_fail++; $display("FAIL empty_pop_misp: got %b want 0", ras_mispredict); end
    jal_ctr = 1; imm26 = 26'h2000; tick(); idle();
    jr_ctr = 1; ret_ctr = 1; rsd = ras_top ^ 32'h10; tick(); idle();
    n_tests++; if (ras_mispredict !== 1'b1) begin n_fail++; $display("FAIL bad_ret_pulse: got %b want 1", ras_mispredict); end
    tick();
    n_tests++; if (ras_mispredict !== 1'b0) begin n_fail++; $display("FAIL bad_ret_clear: got %b want 0", ras_mispredict); end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    jal_ctr = 1; imm26 = 26'h1000; tick();
    imm26 = 26'h1100; tick();
`ifdef FETCH_RAS_EN
    n_tests++; if (ras_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", ras_valid); end
`endif
    reset = 1; stall = 1; jal_ctr = 0; jr_ctr = 1; ret_ctr = 1; rsd = 32'h5555_0000; tick(); idle();
    n_tests++; if (pc !== 32'h3000) begin n_fail++; $display("FAIL mid_reset_pc: got %h want %h", pc, 32'h3000); end
    n_tests++; if (ras_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", ras_valid); end
    n_tests++; if (ras_mispredict !== 1'b0) begin n_fail++; $display("FAIL mid_reset_misp: got %b want 0", ras_mispredict); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 99) < 3);
      stall      = ($urandom_range(0, 99) < 20);
      branch_ctr = ($urandom_range(0, 3) == 0);
      j_ctr      = ($urandom_range(0, 5) == 0);
      jal_ctr    = ($urandom_range(0, 3) == 0);
      jr_ctr     = ($urandom_range(0, 3) == 0);
      ret_ctr    = $urandom_range(0, 1) == 1;
      imm16      = 16'($urandom);
      imm26      = 26'($urandom);
      rsd        = (m_ras.size() > 0 && $urandom_range(0, 1) == 1) ? m_top() : $urandom;
      #1;
      n_tests++; if (npc !== ref_npc()) begin n_fail++; $display("FAIL rnd%0d_npc: got %h want %h", i, npc, ref_npc()); end
      n_tests++; if (jal_pc !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd%0d_jal_pc: got %h want %h", i, jal_pc, m_pc + 32'd4); end
      tick();
      n_tests++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd%0d_pc: got %h want %h", i, pc, m_pc); end
`ifdef FETCH_RAS_EN
      n_tests++; if (ras_valid !== (m_ras.size() > 0)) begin n_fail++; $display("FAIL rnd%0d_valid: got %b want %b", i, ras_valid, m_ras.size() > 0); end
      n_tests++; if (ras_full !== (m_ras.size() == DEPTH)) begin n_fail++; $display("FAIL rnd%0d_full: got %b want %b", i, ras_full, m_ras.size() == DEPTH); end
      n_tests++; if (ras_top !== m_top()) begin n_fail++; $display("FAIL rnd%0d_top: got %h want %h", i, ras_top, m_top()); end
      if (!m_stalled) begin
        n_tests++; if (ras_mispredict !== m_misp) begin n_fail++; $display("FAIL rnd%0d_misp: got %b want %b", i, ras_mispredict, m_misp); end
      end
`else
      n_tests++; if ({ras_top, ras_valid, ras_full, ras_mispredict} !== 35'd0) begin
        n_fail++; $display("FAIL rnd%0d_ras_off: got %h/%b%b%b want all 0", i, ras_top, ras_valid, ras_full, ras_mispredict);
      end
`endif
    end
    idle();
  endtask

  initial begin
    idle();
    m_pc = 32'd0; m_misp = 1'b0; m_stalled = 1'b0;
    test_reset();
    test_idle_seq();
    test_branch();
    test_priority();
`ifdef FETCH_RAS_EN
    test_ras_basic();
    test_ras_overflow();
`endif
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_3000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, meaning the return-address-stack entry count; legal values are powers of two, 2..16.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port stall, input, 1 bit; when high, the PC and all state hold.
REQ-006 SHALL have port branch_ctr, input, 1 bit, meaning a taken conditional branch.
REQ-007 SHALL have port imm16, input, 16 bits, the branch offset in words, signed.
REQ-008 SHALL have ports j_ctr and jal_ctr, inputs, 1 bit each, for an absolute jump and for jump-and-link.
REQ-009 SHALL have port imm26, input, 26 bits, the jump index.
REQ-010 SHALL have port jr_ctr, input, 1 bit, for a register jump; port ret_ctr, input, 1 bit, marks that jr as a return (jr $ra).
REQ-011 SHALL have port rsd, input, 32 bits, the register value used as the jr target.
REQ-012 SHALL have port pc, output, 32 bits, the registered current PC.
REQ-013 SHALL have port npc, output, 32 bits, the combinational next PC.
REQ-014 SHALL have port jal_pc, output, 32 bits, the link address pc+4.
REQ-015 SHALL have ports ras_top (output, 32 bits), ras_valid (output, 1 bit), ras_full (output, 1 bit) and ras_mispredict (output, 1 bit, registered pulse).

Function
REQ-016 Sequential targets SHALL be: seq = pc+4; br = pc+4 + (sign_extend(imm16) << 2); jt = {seq[31:28], imm26, 2'b00}; jr target = rsd. All arithmetic is modulo 2^32.
REQ-017 npc SHALL be selected by fixed priority: jr_ctr > (j_ctr | jal_ctr) > branch_ctr > seq.
REQ-018 Unselected controls SHALL have no side effect.
REQ-019 jal_pc SHALL equal pc+4 at all times, independent of the controls.
REQ-020 pc SHALL load npc every cycle in which reset=0 and stall=0; when stall=1, pc holds.
REQ-021 Latency: npc is visible combinationally in the same cycle; pc reflects it one edge later.
REQ-022 RAS push SHALL occur when jal_ctr is the selected source and stall=0; the pushed value is jal_pc.
REQ-023 RAS pop SHALL occur when jr_ctr=1, ret_ctr=1 and stall=0.
REQ-024 npc SHALL always use rsd on jr, never ras_top.
REQ-025 On a pop with ras_valid=1, ras_mispredict SHALL be 1 in the following cycle if ras_top != rsd, and 0 otherwise.
REQ-026 ras_mispredict SHALL be a one-cycle pulse; it is cleared in any cycle without a qualifying pop.
REQ-027 Pop on empty (ras_valid=0): no state change, no mispredict.
REQ-028 Push on full SHALL overwrite the oldest entry (circular); the occupancy count saturates at RAS_DEPTH and ras_full stays 1.
REQ-029 Push and pop cannot coincide, because jr has priority (REQ-017).
REQ-030 ras_valid = (count != 0); ras_full = (count == RAS_DEPTH); ras_top = the most recent entry, or 0 when empty.
REQ-031 The low two bits of rsd SHALL pass through unmodified; no alignment check is made.

Reset
REQ-032 On a rising edge with reset=1, pc SHALL become RESET_VEC, the RAS count SHALL become 0, and ras_mispredict SHALL become 0.
REQ-033 Reset SHALL take priority over stall and over all controls, including when asserted mid-sequence.
REQ-034 RAS entry contents need not be cleared on reset.

Configuration
REQ-035 Macro FETCH_RAS_EN SHALL control the return-address stack.
REQ-036 With FETCH_RAS_EN defined, the RAS SHALL be implemented per REQ-022..REQ-030.
REQ-037 Without FETCH_RAS_EN, no RAS storage SHALL exist; ras_top, ras_valid, ras_full and ras_mispredict are constant 0, and ret_ctr is ignored.
REQ-038 PC and npc behaviour SHALL be identical with and without FETCH_RAS_EN.

Verification
REQ-039 Reset, then 3 idle cycles: pc sequence SHALL be 0x3000, 0x3004, 0x3008, 0x300C.
REQ-040 At pc=0x3010, branch_ctr=1, imm16=16'hFFFC: npc SHALL be 0x3004. At pc=0x3010, branch_ctr=1, imm16=16'h0003: npc SHALL be 0x3020.
REQ-041 At pc=0x3000, branch_ctr=1 and jr_ctr=1 and j_ctr=1, rsd=0x4000: npc SHALL be 0x4000 and no push SHALL occur. The same stimulus with stall=1: pc SHALL hold at 0x3000.
REQ-042 (FETCH_RAS_EN, depth 4) jal at pc=0x3000, imm26=0x000C40: npc SHALL be 0x3100, ras_top SHALL be 0x3004, ras_valid=1. Then jr with ret_ctr=1 and rsd=0x3004: npc SHALL be 0x3004, ras_mispredict=0 next cycle, ras_valid=0.
REQ-043 (FETCH_RAS_EN) 5 jals with links A1..A5: ras_full=1 and ras_top=A5. Then 4 pops with matching rsd: no mispredict, ras_valid=0. A 5th pop: no pulse. A pop with rsd != ras_top: pulse exactly 1 cycle.
REQ-044 Reset asserted mid-sequence with 2 RAS entries: the next cycle SHALL give pc=0x3000 and ras_valid=0. Without FETCH_RAS_EN, all ras_* outputs SHALL be 0 throughout.
